// File: rtl/qos_pkg.sv
// qos_pkg: shared helpers and default parameters for the QoS queue scheduler.
//   clog2        - width needed to index a number of items (minimum 1)
//   qos_to_class - maps a QoS tag to its class index (top bits of the tag)
//   *_DEF        - default parameter values used by the modules and the bench
package qos_pkg;

  localparam int DSIZE_DEF        = 32;
  localparam int QSIZE_DEF        = 4;
  localparam int NCLASS_DEF       = 4;
  localparam int ASIZE_DEF        = 2;
  localparam int STARVE_LIMIT_DEF = 15;

  function automatic int clog2(input int value);
    int w;
    w = 0;
    for (int i = 0; i < 32; i++) begin
      if ((1 << w) < value) w++;
    end
    return (w == 0) ? 1 : w;
  endfunction

  // Class = the top clog2(nclass) bits of the QoS tag.
  function automatic int qos_to_class(input int qos, input int qsize, input int nclass);
    return qos >> (qsize - clog2(nclass));
  endfunction

endpackage

// File: rtl/qos_queue_sched_if.sv
// qos_queue_sched_if: write/read handshake bundle of the QoS queue scheduler.
//   iWr/iWrData/iQoS  write request, data and QoS tag
//   oFull/oDrop       target class full / previous write was dropped
//   iRd               read request
//   oEmpty            all classes empty
//   oRdValid/oRdData/oRdClass  read response (one cycle after grant)
//   oLevel            per-class occupancy, class k in [k*(ASIZE+1) +: ASIZE+1]
// Modports: slave (the scheduler), master (the requester).
interface qos_queue_sched_if
  import qos_pkg::*;
#(
  parameter int DSIZE  = DSIZE_DEF,
  parameter int QSIZE  = QSIZE_DEF,
  parameter int NCLASS = NCLASS_DEF,
  parameter int ASIZE  = ASIZE_DEF
);
  localparam int CW = clog2(NCLASS);

  logic                        iWr;
  logic [DSIZE-1:0]            iWrData;
  logic [QSIZE-1:0]            iQoS;
  logic                        oFull;
  logic                        oDrop;
  logic                        iRd;
  logic                        oEmpty;
  logic                        oRdValid;
  logic [DSIZE-1:0]            oRdData;
  logic [CW-1:0]               oRdClass;
  logic [NCLASS*(ASIZE+1)-1:0] oLevel;

  modport slave (
    input  iWr, iWrData, iQoS, iRd,
    output oFull, oDrop, oEmpty, oRdValid, oRdData, oRdClass, oLevel
  );

  modport master (
    output iWr, iWrData, iQoS, iRd,
    input  oFull, oDrop, oEmpty, oRdValid, oRdData, oRdClass, oLevel
  );
endinterface

// File: rtl/qos_sync_fifo.sv
// qos_sync_fifo: single-clock FIFO of 2**ASIZE entries with occupancy count.
//   iClk, iResetn  clock / asynchronous active-low reset (pointers, count)
//   iWr, iWrData   push (caller guarantees not full)
//   iRd            pop  (caller guarantees not empty)
//   oRdData        head entry registered on the cycle after iRd
//   oCount         occupancy, ASIZE+1 bits
// The storage array is not reset so it maps onto block RAM; the consumer
// masks oRdData with its own valid flag.
module qos_sync_fifo #(
  parameter int DSIZE = 32,
  parameter int ASIZE = 2
) (
  input  logic             iClk,
  input  logic             iResetn,
  input  logic             iWr,
  input  logic [DSIZE-1:0] iWrData,
  input  logic             iRd,
  output logic [DSIZE-1:0] oRdData,
  output logic [ASIZE:0]   oCount
);
  logic [DSIZE-1:0] r_mem [2**ASIZE];
  logic [DSIZE-1:0] r_rd_data;
  logic [ASIZE-1:0] r_wr_ptr;
  logic [ASIZE-1:0] r_rd_ptr;
  logic [ASIZE:0]   r_count;

  always_ff @(posedge iClk) begin
    if (iWr) r_mem[r_wr_ptr] <= iWrData;
    if (iRd) r_rd_data <= r_mem[r_rd_ptr];
  end

  // Pointers wrap naturally at 2**ASIZE.
  always_ff @(posedge iClk or negedge iResetn) begin
    if (!iResetn) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (iWr) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (iRd) r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({iWr, iRd})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign oRdData = r_rd_data;
  assign oCount  = r_count;
endmodule

// File: rtl/qos_queue_sched.sv
// qos_queue_sched: NCLASS-class QoS queue. Writes go to the class selected
// by the top bits of iQoS; reads pop the highest-index non-empty class.
//   iClk     sole clock, rising edge
//   iResetn  asynchronous active-low reset
//   bus      qos_queue_sched_if.slave (write/read handshake, status, levels)
// Optional feature macro: QOS_AGING_EN - per-class starvation counters; a
// class that lost STARVE_LIMIT grants while non-empty overrides priority.
module qos_queue_sched
  import qos_pkg::*;
#(
  parameter int DSIZE        = DSIZE_DEF,
  parameter int QSIZE        = QSIZE_DEF,
  parameter int NCLASS       = NCLASS_DEF,
  parameter int ASIZE        = ASIZE_DEF,
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
  input logic               iClk,
  input logic               iResetn,
  qos_queue_sched_if.slave  bus
);
  localparam int CW    = clog2(NCLASS);
  localparam int DEPTH = 1 << ASIZE;

  logic [NCLASS-1:0][ASIZE:0]   w_count;
  logic [NCLASS-1:0][DSIZE-1:0] w_head;
  logic [NCLASS-1:0]            w_nonempty;
  logic [NCLASS-1:0]            w_push;
  logic [NCLASS-1:0]            w_pop;
  logic [NCLASS-1:0]            w_aged;
  logic [CW-1:0]                w_wr_cls;
  logic [CW-1:0]                w_sel;
  logic                         w_full;
  logic                         w_empty;
  logic                         w_grant;
  logic                         r_rd_valid;
  logic [CW-1:0]                r_rd_class;
  logic                         r_drop;

  assign w_wr_cls = CW'(qos_to_class(int'(bus.iQoS), QSIZE, NCLASS));
  assign w_full   = (w_count[w_wr_cls] == (ASIZE+1)'(DEPTH));
  assign w_empty  = ~|w_nonempty;
  // Counts are registered, so a write into an empty class is not yet visible here.
  assign w_grant  = bus.iRd && !w_empty;

  for (genvar gi = 0; gi < NCLASS; gi++) begin : g_class
    assign w_nonempty[gi] = (w_count[gi] != '0);
    assign w_push[gi]     = bus.iWr && !w_full && (w_wr_cls == CW'(gi));
    assign w_pop[gi]      = w_grant && (w_sel == CW'(gi));

    qos_sync_fifo #(
      .DSIZE (DSIZE),
      .ASIZE (ASIZE)
    ) u_fifo (
      .iClk    (iClk),
      .iResetn (iResetn),
      .iWr     (w_push[gi]),
      .iWrData (bus.iWrData),
      .iRd     (w_pop[gi]),
      .oRdData (w_head[gi]),
      .oCount  (w_count[gi])
    );

`ifdef QOS_AGING_EN
    localparam int AW = clog2(STARVE_LIMIT + 1);
    logic [AW-1:0] r_age;

    assign w_aged[gi] = w_nonempty[gi] && (r_age == AW'(STARVE_LIMIT));

    // Served class restarts; every other waiting class ages by one grant.
    always_ff @(posedge iClk or negedge iResetn) begin
      if (!iResetn) begin
        r_age <= '0;
      end else if (w_grant) begin
        if (w_sel == CW'(gi))
          r_age <= '0;
        else if (w_nonempty[gi] && (r_age != AW'(STARVE_LIMIT)))
          r_age <= r_age + 1'b1;
      end
    end
`else
    assign w_aged[gi] = 1'b0;
`endif
  end

  // Later (higher-index) hits overwrite earlier ones; aged classes beat plain priority.
  always_comb begin
    w_sel = '0;
    for (int k = 0; k < NCLASS; k++) begin
      if (w_nonempty[k]) w_sel = CW'(k);
    end
    for (int k = 0; k < NCLASS; k++) begin
      if (w_aged[k]) w_sel = CW'(k);
    end
  end

  always_ff @(posedge iClk or negedge iResetn) begin
    if (!iResetn) begin
      r_rd_valid <= 1'b0;
      r_rd_class <= '0;
      r_drop     <= 1'b0;
    end else begin
      r_rd_valid <= w_grant;
      if (w_grant) r_rd_class <= w_sel;
      r_drop     <= bus.iWr && w_full;
    end
  end

  assign bus.oFull    = w_full;
  assign bus.oDrop    = r_drop;
  assign bus.oEmpty   = w_empty;
  assign bus.oRdValid = r_rd_valid;
  assign bus.oRdData  = r_rd_valid ? w_head[r_rd_class] : '0;
  assign bus.oRdClass = r_rd_class;
  assign bus.oLevel   = w_count;
endmodule

// File: tb/tb_qos_queue_sched.sv
module tb_qos_queue_sched;
  import qos_pkg::*;

  localparam int DSIZE        = 32;
  localparam int QSIZE        = 4;
  localparam int NCLASS       = 4;
  localparam int ASIZE        = 2;
  localparam int STARVE_LIMIT = 3;
  localparam int DEPTH        = 1 << ASIZE;
  localparam int CW           = clog2(NCLASS);

  logic iClk    = 1'b0;
  logic iResetn = 1'b0;
  always #5 iClk = ~iClk;

  qos_queue_sched_if #(.DSIZE(DSIZE), .QSIZE(QSIZE), .NCLASS(NCLASS), .ASIZE(ASIZE)) bus();

  qos_queue_sched #(
    .DSIZE(DSIZE), .QSIZE(QSIZE), .NCLASS(NCLASS), .ASIZE(ASIZE), .STARVE_LIMIT(STARVE_LIMIT)
  ) dut (
    .iClk    (iClk),
    .iResetn (iResetn),
    .bus     (bus)
  );

  typedef struct {
    bit          valid;
    logic [31:0] data;
    int          cls;
    bit          drop;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] model_q[NCLASS][$];
  int          age[NCLASS];
  int          n_checks = 0;
  int          n_fail   = 0;

  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    end
  endfunction

  // Monitor: registered outputs sampled mid-cycle, compared with the scoreboard.
  initial begin
    exp_t e;
    forever begin
      @(negedge iClk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("rd_valid", 64'(bus.oRdValid), 64'(e.valid));
        check("rd_data", 64'(bus.oRdData), 64'(e.data));
        if (e.valid) begin
          check("rd_class", 64'(bus.oRdClass), 64'(e.cls));
          $display("read  class=%0d data=%h", bus.oRdClass, bus.oRdData);
        end
        check("drop", 64'(bus.oDrop), 64'(e.drop));
      end else begin
        check("idle_outputs", 64'({bus.oRdValid, bus.oDrop}), 64'(0));
      end
    end
  end

  // One clock of stimulus: drive, check combinational status, advance the model.
  task automatic cycle(input bit wr, input logic [31:0] data, input logic [3:0] qos, input bit rd);
    int   cls;
    int   sel;
    bit   any;
    bit   full;
    bit   grant;
    exp_t e;
    @(negedge iClk);
    bus.iWr     = wr;
    bus.iWrData = data;
    bus.iQoS    = qos;
    bus.iRd     = rd;
    #1;
    cls  = int'(qos) / ((1 << QSIZE) / NCLASS);
    full = (model_q[cls].size() == DEPTH);
    any  = 1'b0;
    for (int k = 0; k < NCLASS; k++) if (model_q[k].size() > 0) any = 1'b1;
    check("full", 64'(bus.oFull), 64'(full));
    check("empty", 64'(bus.oEmpty), 64'(!any));
    for (int k = 0; k < NCLASS; k++)
      check("level", 64'(bus.oLevel[k*(ASIZE+1) +: ASIZE+1]), 64'(model_q[k].size()));

    grant = rd && any;
    sel   = -1;
    if (grant) begin
`ifdef QOS_AGING_EN
      for (int k = 0; k < NCLASS; k++)
        if (age[k] >= STARVE_LIMIT && model_q[k].size() > 0) sel = k;
`endif
      if (sel < 0)
        for (int k = 0; k < NCLASS; k++) if (model_q[k].size() > 0) sel = k;
    end
`ifdef QOS_AGING_EN
    if (grant)
      for (int k = 0; k < NCLASS; k++) begin
        if (k == sel) age[k] = 0;
        else if (model_q[k].size() > 0 && age[k] < STARVE_LIMIT) age[k]++;
      end
`endif
    e.valid = grant;
    e.data  = '0;
    e.cls   = 0;
    if (grant) begin
      e.data = model_q[sel].pop_front();
      e.cls  = sel;
    end
    e.drop = wr && full;
    if (wr && !full) model_q[cls].push_back(data);
    exp_q.push_back(e);
    if (wr) $display("write qos=%h data=%h %s", qos, data, full ? "dropped" : "accepted");
  endtask

  task automatic reset_mid();
    @(negedge iClk);
    #2;
    iResetn     = 1'b0;
    bus.iWr     = 1'b0;
    bus.iRd     = 1'b0;
    bus.iQoS    = '0;
    bus.iWrData = '0;
    #1;
    check("rst_rd_valid", 64'(bus.oRdValid), 64'(0));
    check("rst_rd_data", 64'(bus.oRdData), 64'(0));
    check("rst_rd_class", 64'(bus.oRdClass), 64'(0));
    check("rst_drop", 64'(bus.oDrop), 64'(0));
    check("rst_empty", 64'(bus.oEmpty), 64'(1));
    check("rst_full", 64'(bus.oFull), 64'(0));
    check("rst_level", 64'(bus.oLevel), 64'(0));
    $display("reset asserted mid-operation");
    for (int k = 0; k < NCLASS; k++) begin
      model_q[k].delete();
      age[k] = 0;
    end
    exp_q.delete();
    repeat (2) @(negedge iClk);
    #2;
    iResetn = 1'b1;
  endtask

  initial begin
    bus.iWr     = 1'b0;
    bus.iWrData = '0;
    bus.iQoS    = '0;
    bus.iRd     = 1'b0;
    for (int k = 0; k < NCLASS; k++) age[k] = 0;
    repeat (3) @(negedge iClk);
    #1;
    check("init_empty", 64'(bus.oEmpty), 64'(1));
    check("init_level", 64'(bus.oLevel), 64'(0));
    check("init_rd_valid", 64'(bus.oRdValid), 64'(0));
    iResetn = 1'b1;

    // Idle, then a read on an empty queue.
    cycle(0, 0, 4'h0, 0);
    cycle(0, 0, 4'h0, 1);
    cycle(0, 0, 4'h0, 0);

    // Priority: class 0 fill, one class 3 entry, five reads.
    for (int i = 0; i < 4; i++) cycle(1, 32'hA0 + 32'(i), 4'h0, 0);
    cycle(1, 32'hB0, 4'hF, 0);
    repeat (5) cycle(0, 0, 4'h0, 1);
    cycle(0, 0, 4'h0, 0);

    // Fill class 1 and overflow it.
    for (int i = 0; i < 5; i++) cycle(1, 32'h100 + 32'(i), 4'h5, 0);
    cycle(0, 0, 4'h5, 0);

    // Class 2 at count 3, then write and read it in the same cycle.
    for (int i = 0; i < 3; i++) cycle(1, 32'h200 + 32'(i), 4'h8, 0);
    cycle(1, 32'h203, 4'h9, 1);
    repeat (9) cycle(0, 0, 4'h0, 1);

    // Starvation scenario: class 3 kept busy, one class 0 entry waiting.
    cycle(1, 32'h300, 4'h0, 0);
    for (int i = 0; i < 4; i++) cycle(1, 32'h310 + 32'(i), 4'hC, 0);
    for (int i = 0; i < 6; i++) cycle(1, 32'h320 + 32'(i), 4'hD, 1);
    repeat (8) cycle(0, 0, 4'h0, 1);

    // Reset while classes 0 and 3 hold data.
    cycle(1, 32'h400, 4'h1, 0);
    cycle(1, 32'h401, 4'hE, 0);
    reset_mid();
    cycle(0, 0, 4'h0, 0);
    cycle(0, 0, 4'h0, 1);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++)
      cycle($urandom_range(0, 99) < 60, $urandom, 4'($urandom_range(0, 15)),
            $urandom_range(0, 99) < 50);
    repeat (12) cycle(0, 0, 4'h0, 1);

    @(negedge iClk);
    @(negedge iClk);
    check("scoreboard_drained", 64'(exp_q.size()), 64'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/qos_queue_sched.md
# qos_queue_sched

Single-clock, parametrised multi-class QoS queue for the interconnect datapath. Writes are steered into one of NCLASS per-class FIFOs by the top bits of the QoS tag. Reads drain the highest-priority non-empty class, with optional anti-starvation aging. Sits between master-side request capture and the slave-side port; it is the single-clock, N-class generalisation of the existing QoS FIFO wrapper, with real drop reporting and per-class occupancy.

## Interface
- DSIZE, 32: data width
- QSIZE, 4: QoS tag width
- NCLASS, 4: number of classes; power of two, 2..2**QSIZE
- ASIZE, 2: per-class depth is 2**ASIZE entries
- STARVE_LIMIT, 15: aging threshold in lost grants (used only with aging compiled in)

Ports:
- iClk  in  1  sole clock, rising edge
- iResetn  in  1  reset, asynchronous assert, active-low
- iWr  in  1  write request
- iWrData  in  DSIZE  write data
- iQoS  in  QSIZE  QoS tag of the current write
- oFull  out  1  target class of the current iQoS is full (combinational)
- oDrop  out  1  one-cycle pulse: the previous cycle's write was dropped
- iRd  in  1  read request
- oEmpty  out  1  all classes empty
- oRdValid  out  1  oRdData/oRdClass valid this cycle
- oRdData  out  DSIZE  read data
- oRdClass  out  log2(NCLASS)  class that supplied oRdData
- oLevel  out  NCLASS*(ASIZE+1)  per-class occupancy; class k in bits [k*(ASIZE+1) +: ASIZE+1]

## Operation
- Class map: cls = iQoS[QSIZE-1 -: log2(NCLASS)]. Higher class index means higher priority.
- Write: iWr & ~oFull enqueues iWrData into class cls in the same cycle.
- Drop: iWr & oFull discards the write; oDrop=1 on the next cycle.
- Read grant: on iRd & ~oEmpty, select the highest-index class with a non-zero count and pop its head. Grant uses counts registered at the start of the cycle.
- iRd & oEmpty is ignored: no pop, oRdValid=0 next cycle.
- Same class written and popped in one cycle: count is unchanged; data order is preserved.
- A write to an empty class is not grantable until the next cycle.
- Pointers wrap modulo 2**ASIZE. Count is ASIZE+1 bits; full when count == 2**ASIZE.
- oEmpty = all counts zero. oFull = count[cls] == 2**ASIZE.
- Reset mid-operation clears every count, pointer, aging counter and output register. Queued data is lost; RAM contents are don't-care.

## Timing
- Reset values: oRdValid=0, oRdData=0, oRdClass=0, oDrop=0, oEmpty=1, oFull=0, oLevel=0.
- Read latency is 1: a grant in cycle N gives oRdValid=1, oRdData and oRdClass in N+1.
- With no grant: oRdValid=0 and oRdData=0.
- Write accepted in cycle N: oLevel and oEmpty update in N+1.
- oDrop is asserted for exactly one cycle per dropped write.
- Throughput: one write and one read per cycle, sustained.

## Configuration
- QOS_AGING_EN defined:
  - Each class has a counter up to STARVE_LIMIT.
  - On every grant, each non-empty class that was not served increments its counter (saturating). The served class clears its counter.
  - Any class whose counter equals STARVE_LIMIT overrides strict priority. Among aged classes, the highest index wins.
- QOS_AGING_EN undefined: pure strict priority; no aging logic is generated.

## Structure
- Package qos_pkg holds:
  - class-index width function clog2
  - QoS-to-class mapping function
  - default parameter constants
- Sub-module qos_sync_fifo: single-clock FIFO with count output, one instance per class via generate.
- Arbiter and aging logic live in the top module.

## Test plan
- Reset then idle: oEmpty=1, oRdValid=0, oLevel=0. An iRd pulse gives oRdValid=0 next cycle.
- Write 0xA0..0xA3 at iQoS=0x0, then 0xB0 at 0xF. Five reads return 0xB0 (class 3), then 0xA0..0xA3 (class 0), each 1 cycle after iRd.
- Fill class 1 with 4 writes at iQoS=0x5. A fifth write sees oFull=1; next cycle oDrop=1 and oLevel class1=4.
- Simultaneous write and read on class 2 when its count is 3: count stays 3, FIFO order preserved, no drop.
- QOS_AGING_EN, STARVE_LIMIT=3:
  - Setup: keep class 3 non-empty and hold one entry in class 0 while reading continuously.
  - Expected: the 4th grant serves class 0.
  - Without the macro, class 0 is never served while class 3 is non-empty.
- Assert iResetn low while classes 0 and 3 hold data: all outputs return to reset values asynchronously; after release, oEmpty=1.
